// File: rtl/io_out_port_if.sv
// Bus-side and consumer-side signals of the output port, grouped so the
// controller/consumer (master) and the port (slave) see matching directions.
interface io_out_port_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] bus_O1_input;
  logic             bus_O1_load_en;
  logic             bus_O1_status_en;
  logic             O1_clear_err;
  logic [WIDTH-1:0] external_O1_output;
  logic             external_O1_valid;
  logic             external_O1_ready;
  logic             O1_full;
  logic             O1_empty;
  logic             O1_overflow;

  modport master (
    output bus_O1_input, bus_O1_load_en, bus_O1_status_en, O1_clear_err,
           external_O1_ready,
    input  external_O1_output, external_O1_valid, O1_full, O1_empty,
           O1_overflow
  );

  modport slave (
    input  bus_O1_input, bus_O1_load_en, bus_O1_status_en, O1_clear_err,
           external_O1_ready,
    output external_O1_output, external_O1_valid, O1_full, O1_empty,
           O1_overflow
  );
endinterface

// File: rtl/io_out_port.sv
// Bus-to-external output port: captures bus words into a small FIFO, hands
// them to a valid/ready consumer, and exposes a pollable status word.
module io_out_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             O1_clock,
  input  logic             O1_reset,
  io_out_port_if.slave     bus,
  output wire  [WIDTH-1:0] bus_O1_status
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             full, empty, valid, pop, push, drop;
  logic [WIDTH-1:0] status_word;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign valid = !empty;
  assign pop   = valid & bus.external_O1_ready;
  assign push  = bus.bus_O1_load_en & (!full | pop);
  assign drop  = bus.bus_O1_load_en & full & !pop;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.bus_O1_input;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear wins, so no lost word goes unreported.
    if (drop)                  overflow_d = 1'b1;
    else if (bus.O1_clear_err) overflow_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge O1_clock) begin
    if (O1_reset) begin
      // NOTE: storage is cleared on reset so the head output never exposes
      // stale data from before reset.
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.external_O1_output = valid ? mem_q[rd_ptr_q] : '0;
  assign bus.external_O1_valid  = valid;
  assign bus.O1_full            = full;
  assign bus.O1_empty           = empty;
  assign bus.O1_overflow        = overflow_q;

  always_comb begin
    status_word          = '0;
    status_word[WIDTH-1] = overflow_q;
    status_word[WIDTH-2] = full;
    status_word[WIDTH-3] = empty;
    status_word[CW-1:0]  = count_q;
  end

  tri_state_buffer #(.WIDTH(WIDTH)) u_status_buf (
    .en       (bus.bus_O1_status_en),
    .data_in  (status_word),
    .data_out (bus_O1_status)
  );
endmodule

// Shared-bus driver: releases the bus whenever its enable is low.
module tri_state_buffer #(
  parameter int WIDTH = 16
) (
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output wire  [WIDTH-1:0] data_out
);
  assign data_out = en ? data_in : {WIDTH{1'bz}};
endmodule

// File: tb/tb_io_out_port.sv
// Self-checking bench for io_out_port: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_io_out_port;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire  [WIDTH-1:0] bus_status;

  io_out_port_if #(.WIDTH(WIDTH)) bus_if ();

  io_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .O1_clock      (clk),
    .O1_reset      (rst),
    .bus           (bus_if.slave),
    .bus_O1_status (bus_status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the FIFO contents as a plain queue plus a sticky flag.
  logic [WIDTH-1:0] mq[$];
  logic             movf = 1'b0;

  typedef struct {
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             rdy;
    logic             clr;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_out;
    logic [WIDTH-1:0] exp_status;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_hiz(input string name);
    n_checks++;
    if (bus_status === {WIDTH{1'bz}} || bus_status === {WIDTH{1'b0}}) n_pass++;
    else $display("FAIL %s: got %h expected hi-Z", name, bus_status);
  endtask

  function automatic logic [WIDTH-1:0] model_status();
    logic [WIDTH-1:0] s;
    s        = '0;
    s[15]    = movf;
    s[14]    = (mq.size() == DEPTH);
    s[13]    = (mq.size() == 0);
    s[2:0]   = 3'(mq.size());
    return s;
  endfunction

  // Apply one cycle of inputs, advance the model by the same rules, then
  // settle just after the edge so outputs can be sampled.
  task automatic step(input logic ld, input logic [WIDTH-1:0] d, input logic rdy,
                      input logic clr, input logic do_rst);
    logic m_pop, m_full;
    bus_if.bus_O1_load_en    = ld;
    bus_if.bus_O1_input      = d;
    bus_if.external_O1_ready = rdy;
    bus_if.O1_clear_err      = clr;
    rst                      = do_rst;
    if (do_rst) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      m_pop  = (mq.size() != 0) && rdy;
      m_full = (mq.size() == DEPTH);
      if (ld && m_full && !m_pop) movf = 1'b1;
      else if (clr)               movf = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (ld && (!m_full || m_pop)) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 32'(bus_if.external_O1_valid), 32'(mq.size() != 0));
    check({tag, "_out"}, 32'(bus_if.external_O1_output),
          32'((mq.size() != 0) ? mq[0] : '0));
    if (bus_if.bus_O1_status_en) check({tag, "_status"}, 32'(bus_status), 32'(model_status()));
    else                         check_hiz({tag, "_hiz"});
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h0001};
    tbl[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h0002};
    tbl[2]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h0003};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h0003};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h2222, 16'h0002};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3333, 16'h0001};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h2000};
    tbl[7]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'h0001};
    tbl[8]  = '{1'b1, 16'h00A2, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'h0002};
    tbl[9]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'h0003};
    tbl[10] = '{1'b1, 16'h00A4, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'h4004};
    tbl[11] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'hC004};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h00A1, 16'h4004};
    tbl[13] = '{1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b1, 16'h00A1, 16'hC004};
    tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h00A1, 16'h4004};
    tbl[15] = '{1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'h00A2, 16'h4004};
    tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h00A3, 16'h0003};
    tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h00A4, 16'h0002};
    tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0001};
    tbl[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h2000};
    tbl[20] = '{1'b1, 16'h0055, 1'b1, 1'b0, 1'b1, 16'h0055, 16'h0001};
    tbl[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h2000};

    bus_if.bus_O1_status_en = 1'b1;
    step(1'b1, 16'h9999, 1'b1, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("rst_valid", 32'(bus_if.external_O1_valid), 32'd0);
    check("rst_out", 32'(bus_if.external_O1_output), 32'h0);
    check("rst_empty", 32'(bus_if.O1_empty), 32'd1);
    check("rst_full", 32'(bus_if.O1_full), 32'd0);
    check("rst_ovf", 32'(bus_if.O1_overflow), 32'd0);
    check("rst_status", 32'(bus_status), 32'h2000);

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].d, tbl[i].rdy, tbl[i].clr, 1'b0);
      check($sformatf("vec%0d_valid", i), 32'(bus_if.external_O1_valid), 32'(tbl[i].exp_valid));
      check($sformatf("vec%0d_out", i), 32'(bus_if.external_O1_output), 32'(tbl[i].exp_out));
      check($sformatf("vec%0d_status", i), 32'(bus_status), 32'(tbl[i].exp_status));
    end

    // Streaming: each word appears the cycle after it is pushed, count stays 1.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
      check($sformatf("stream%0d_out", i), 32'(bus_if.external_O1_output), 32'(i));
      check($sformatf("stream%0d_status", i), 32'(bus_status), 32'h0001);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("stream_drained", 32'(bus_status), 32'h2000);

    // Reset while holding 3 entries with overflow set and a push in flight.
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0C00 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("pre_rst_status", 32'(bus_status), 32'h8003);
    step(1'b1, 16'h7777, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus_if.external_O1_valid), 32'd0);
    check("mid_rst_empty", 32'(bus_if.O1_empty), 32'd1);
    check("mid_rst_ovf", 32'(bus_if.O1_overflow), 32'd0);
    check("mid_rst_out", 32'(bus_if.external_O1_output), 32'h0);
    check("mid_rst_status", 32'(bus_status), 32'h2000);

    bus_if.bus_O1_status_en = 1'b0;
    #1;
    check_hiz("hiz_empty");
    step(1'b1, 16'h4242, 1'b0, 1'b0, 1'b0);
    check_hiz("hiz_one");
    bus_if.bus_O1_status_en = 1'b1;
    #1;
    check("en_one_status", 32'(bus_status), 32'h0001);
    bus_if.bus_O1_status_en = 1'b0;
    #1;
    check_hiz("hiz_fall");

    for (int i = 0; i < 400; i++) begin
      bus_if.bus_O1_status_en = ($urandom_range(0, 99) < 85);
      step($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 10, 1'b0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
